wb_port_arbiter: RTL

- Shares the single register-file write port between two requesters: the MEM/WB pipeline result and the multi-cycle unit (MCU, mul/div) result.
- The pipeline has priority by default. The MCU is starvation-protected: after MAXWAIT lost cycles, the pipeline is stalled for one cycle and the MCU is granted.
- The registered write port also feeds the forwarding network. Sits between the MEM/WB buffer and the register file.

---
 rtl/wb_port_arbiter_if.sv | 44 ++++
 rtl/wb_port_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle: pipeline (MEM/WB) request, MCU valid/ready
// request, and the registered register-file write / forwarding outputs.
// master = requesters + consumers side, slave = the arbiter.
interface wb_port_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  // pipeline requester
  logic          pipe_req;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_word;
  logic [7:0]    pipe_byte;
  logic          pipe_is_byte;
  logic          stall_o;
  // multi-cycle unit requester
  logic          mcu_valid;
  logic [AW-1:0] mcu_addr;
  logic [DW-1:0] mcu_data;
  logic          mcu_ready;
  // register-file write port
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  // forwarding copy of the write port
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;

  modport master (
    output pipe_req, pipe_addr, pipe_word, pipe_byte, pipe_is_byte,
    output mcu_valid, mcu_addr, mcu_data,
    input  mcu_ready, stall_o,
    input  rf_we, rf_addr, rf_data,
    input  fwd_valid, fwd_addr, fwd_data
  );

  modport slave (
    input  pipe_req, pipe_addr, pipe_word, pipe_byte, pipe_is_byte,
    input  mcu_valid, mcu_addr, mcu_data,
    output mcu_ready, stall_o,
    output rf_we, rf_addr, rf_data,
    output fwd_valid, fwd_addr, fwd_data
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Purpose: shares the single register-file write port between the MEM/WB
//   pipeline (priority) and the MCU (starvation-protected after MAXWAIT losses).
// Latency: 1 cycle from accepted transfer to rf_*/fwd_* (registered).
// Backpressure: mcu_ready (combinational) throttles the MCU; stall_o holds the
//   pipeline for the single forced-MCU cycle.
// Ports: clk, rst (sync, active-high); bus = wb_port_arbiter_if.slave.
module wb_port_arbiter #(
  parameter int DW           = 16,
  parameter int AW           = 3,
  parameter int MAXWAIT      = 4,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
);

  typedef enum logic {ST_PIPE, ST_FORCE} state_t;

  localparam logic [3:0] MAXW    = 4'(MAXWAIT);
  localparam logic [3:0] MAXW_M1 = 4'(MAXWAIT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_wait_cnt;
  logic [3:0]    w_wait_nxt;
  logic          w_mcu_ready;
  logic          w_stall;
  logic          w_pipe_xfer;
  logic          w_mcu_xfer;
  logic [DW-1:0] w_pipe_data;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  always_comb begin
    w_state_nxt = r_state;
    w_mcu_ready = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      ST_PIPE: begin
        w_mcu_ready = !bus.pipe_req;
        // The MCU is losing its MAXWAIT-th cycle now: grant it next cycle.
        if (bus.mcu_valid && bus.pipe_req && r_wait_cnt == MAXW_M1)
          w_state_nxt = ST_FORCE;
      end
      ST_FORCE: begin
        w_stall     = 1'b1;
        w_mcu_ready = 1'b1;
        w_state_nxt = ST_PIPE;
      end
      default: w_state_nxt = ST_PIPE;
    endcase
    // Nothing is accepted in a reset cycle, even a forced MCU grant.
    if (rst) begin
      w_mcu_ready = 1'b0;
      w_stall     = 1'b0;
    end
  end

  assign w_pipe_xfer = (r_state == ST_PIPE) && bus.pipe_req && !rst;
  assign w_mcu_xfer  = bus.mcu_valid && w_mcu_ready;
  assign w_pipe_data = bus.pipe_is_byte ? {{(DW-8){1'b0}}, bus.pipe_byte}
                                        : bus.pipe_word;

  // Consecutive cycles the MCU has been refused; saturates at MAXWAIT.
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!bus.mcu_valid || w_mcu_xfer)
      w_wait_nxt = 4'd0;
    else if (r_wait_cnt < MAXW)
      w_wait_nxt = r_wait_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_PIPE;
      r_wait_cnt <= 4'd0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      // Writes to r0 complete the handshake but never assert the enable.
      if (w_pipe_xfer) begin
        r_we   <= !(R0_HARDWIRED && bus.pipe_addr == '0);
        r_addr <= bus.pipe_addr;
        r_data <= w_pipe_data;
      end else if (w_mcu_xfer) begin
        r_we   <= !(R0_HARDWIRED && bus.mcu_addr == '0);
        r_addr <= bus.mcu_addr;
        r_data <= bus.mcu_data;
      end else begin
        r_we   <= 1'b0;
      end
    end
  end

  assign bus.mcu_ready = w_mcu_ready;
  assign bus.stall_o   = w_stall;
  assign bus.rf_we     = r_we;
  assign bus.rf_addr   = r_addr;
  assign bus.rf_data   = r_data;
  // Forwarding taps the same registers: no extra latency, no own state.
  assign bus.fwd_valid = r_we;
  assign bus.fwd_addr  = r_addr;
  assign bus.fwd_data  = r_data;

endmodule
